// File: rtl/nand_async_cycle_gen.sv
// nand_async_cycle_gen
//   Asynchronous-mode NAND bus-cycle generator. Turns one request (CMD, ADDR,
//   DIN write or DOUT read) into a SETUP / PULSE / HOLD pin sequence on
//   CLE, ALE, WE#, RE#, CE# and the DQ output enable. All pin-facing outputs
//   are registered in clk0.
//
// Parameters
//   DQ_WIDTH  DQ bus width
//   NUM_CE    number of chip enables (>=1)
//   T_SETUP   cycles in SETUP (>=1)
//   T_PULSE   cycles WE#/RE# are held low (>=1)
//   T_HOLD    cycles in HOLD (>=1)
//   CE_IDLE   idle cycles CE# stays low after a bus cycle (0 = release at once)
//
// Ports
//   clk0, rst0         clock, async active-high reset
//   req_valid/ready    request handshake, accepted in IDLE only
//   req_type           0=CMD 1=ADDR 2=DIN 3=DOUT
//   req_ce, req_data   target CE index, command/address/write byte
//   rsp_valid/data     one-cycle pulse carrying the captured read byte
//   err                one-cycle pulse for an out-of-range req_ce
//   cle, ale, wen, wrn NAND strobes (wen/wrn active low)
//   cen                CE#, one-hot-low
//   dq_out, dq_oe_n    DQ drive value and active-low output enable
//   dq_in              DQ pad input
module nand_async_cycle_gen #(
  parameter int DQ_WIDTH = 8,
  parameter int NUM_CE   = 2,
  parameter int T_SETUP  = 1,
  parameter int T_PULSE  = 2,
  parameter int T_HOLD   = 1,
  parameter int CE_IDLE  = 4,
  localparam int CE_W    = (NUM_CE > 1) ? $clog2(NUM_CE) : 1
) (
  input  logic                clk0,
  input  logic                rst0,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_type,
  input  logic [CE_W-1:0]     req_ce,
  input  logic [DQ_WIDTH-1:0] req_data,
  output logic                rsp_valid,
  output logic [DQ_WIDTH-1:0] rsp_data,
  output logic                err,
  output logic                cle,
  output logic                ale,
  output logic                wen,
  output logic                wrn,
  output logic [NUM_CE-1:0]   cen,
  output logic [DQ_WIDTH-1:0] dq_out,
  output logic                dq_oe_n,
  input  logic [DQ_WIDTH-1:0] dq_in
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD} state_t;
  typedef enum logic [1:0] {RT_CMD, RT_ADDR, RT_DIN, RT_DOUT} rtype_t;

  localparam int T_MAX = (T_SETUP > T_PULSE) ?
                         ((T_SETUP > T_HOLD) ? T_SETUP : T_HOLD) :
                         ((T_PULSE > T_HOLD) ? T_PULSE : T_HOLD);
  // Timer holds "cycles left minus one" so it only needs T_MAX-1.
  localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam int IW    = (CE_IDLE > 0) ? $clog2(CE_IDLE + 1) : 1;

  state_t               state_q, state_d;
  logic [TW-1:0]        tmr_q, tmr_d;
  logic [IW-1:0]        idle_q, idle_d;
  rtype_t               type_q, type_d;

  logic                 ready_d, rsp_valid_d, err_d;
  logic [DQ_WIDTH-1:0]  rsp_data_d, dq_out_d;
  logic                 cle_d, ale_d, wen_d, wrn_d, dq_oe_n_d;
  logic [NUM_CE-1:0]    cen_d;

  logic                 accept, ce_bad, accept_ok, accept_bad, tmr_done, pulse_d;

  assign accept     = (state_q == S_IDLE) && req_valid && req_ready;
  assign ce_bad     = (32'(req_ce) >= 32'(NUM_CE));
  assign accept_ok  = accept && !ce_bad;
  assign accept_bad = accept && ce_bad;
  assign tmr_done   = (tmr_q == '0);

  // State register plus all registered pins.
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      state_q   <= S_IDLE;
      tmr_q     <= '0;
      idle_q    <= '0;
      type_q    <= RT_CMD;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      err       <= 1'b0;
      cle       <= 1'b0;
      ale       <= 1'b0;
      wen       <= 1'b1;
      wrn       <= 1'b1;
      cen       <= '1;
      dq_out    <= '0;
      dq_oe_n   <= 1'b1;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      idle_q    <= idle_d;
      type_q    <= type_d;
      req_ready <= ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
      err       <= err_d;
      cle       <= cle_d;
      ale       <= ale_d;
      wen       <= wen_d;
      wrn       <= wrn_d;
      cen       <= cen_d;
      dq_out    <= dq_out_d;
      dq_oe_n   <= dq_oe_n_d;
    end
  end

  // Next state. One down-counter, reloaded with (T-1) on every state entry.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_done ? tmr_q : tmr_q - TW'(1);
    type_d  = type_q;
    case (state_q)
      S_IDLE: begin
        if (accept_ok) begin
          state_d = S_SETUP;
          tmr_d   = TW'(T_SETUP - 1);
          type_d  = rtype_t'(req_type);
        end
      end
      S_SETUP: begin
        if (tmr_done) begin
          state_d = S_PULSE;
          tmr_d   = TW'(T_PULSE - 1);
        end
      end
      S_PULSE: begin
        if (tmr_done) begin
          state_d = S_HOLD;
          tmr_d   = TW'(T_HOLD - 1);
        end
      end
      S_HOLD: begin
        if (tmr_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next pin values. The cen and dq_out registers double as the latched
  // CE index and data byte, so only the request type needs its own latch.
  always_comb begin
    ready_d     = (state_d == S_IDLE);
    err_d       = accept_bad;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data;
    cle_d       = cle;
    ale_d       = ale;
    cen_d       = cen;
    dq_out_d    = dq_out;
    dq_oe_n_d   = dq_oe_n;
    idle_d      = idle_q;
    pulse_d     = (state_d == S_PULSE);
    wen_d       = !(pulse_d && (type_q != RT_DOUT));
    wrn_d       = !(pulse_d && (type_q == RT_DOUT));
    case (state_q)
      S_IDLE: begin
        if (accept_ok) begin
          // Same CE inside the hold-off window rewrites an identical value,
          // a different CE swaps the low bit in this single edge.
          for (int i = 0; i < NUM_CE; i++) cen_d[i] = (req_ce != CE_W'(i));
          cle_d     = (rtype_t'(req_type) == RT_CMD);
          ale_d     = (rtype_t'(req_type) == RT_ADDR);
          dq_oe_n_d = (rtype_t'(req_type) == RT_DOUT);
          if (rtype_t'(req_type) != RT_DOUT) dq_out_d = req_data;
          idle_d    = '0;
        end else if (idle_q == IW'(1)) begin
          cen_d  = '1;
          idle_d = '0;
        end else if (idle_q != '0) begin
          idle_d = idle_q - IW'(1);
        end
      end
      S_PULSE: begin
        // Read byte is sampled on the edge that ends the last PULSE cycle.
        if (tmr_done && (type_q == RT_DOUT)) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = dq_in;
        end
      end
      S_HOLD: begin
        if (tmr_done) begin
          cle_d     = 1'b0;
          ale_d     = 1'b0;
          dq_oe_n_d = 1'b1;
          if (CE_IDLE == 0) cen_d  = '1;
          else              idle_d = IW'(CE_IDLE);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_nand_async_cycle_gen.sv
module tb_nand_async_cycle_gen;
  localparam int ND = 2;
  localparam logic [1:0] T_CMD = 2'd0, T_ADDR = 2'd1, T_DIN = 2'd2, T_DOUT = 2'd3;

  // dut 0: 4 CEs, 2/3/1 timing, 4-cycle CE hold-off; dut 1: 3 CEs, defaults, no hold-off
  int nce[ND] = '{4, 3};
  int ts[ND]  = '{2, 1};
  int tp[ND]  = '{3, 2};
  int th[ND]  = '{1, 1};
  int tid[ND] = '{4, 0};

  logic clk0 = 1'b0, rst0 = 1'b1;
  always #5 clk0 = ~clk0;
  int ecnt = 0;
  always @(posedge clk0) ecnt <= ecnt + 1;

  logic       req_valid[ND];
  logic [1:0] req_type[ND], req_ce[ND];
  logic [7:0] req_data[ND], dq_in[ND];
  logic       rdy[ND], rv[ND], err[ND], cle[ND], ale[ND], wen[ND], wrn[ND], oen[ND];
  logic [7:0] rd[ND], dqo[ND];
  logic [3:0] cen0;
  logic [2:0] cen1;

  nand_async_cycle_gen #(.DQ_WIDTH(8), .NUM_CE(4), .T_SETUP(2), .T_PULSE(3), .T_HOLD(1), .CE_IDLE(4)) dut0 (
    .clk0(clk0), .rst0(rst0), .req_valid(req_valid[0]), .req_ready(rdy[0]), .req_type(req_type[0]),
    .req_ce(req_ce[0]), .req_data(req_data[0]), .rsp_valid(rv[0]), .rsp_data(rd[0]), .err(err[0]),
    .cle(cle[0]), .ale(ale[0]), .wen(wen[0]), .wrn(wrn[0]), .cen(cen0), .dq_out(dqo[0]),
    .dq_oe_n(oen[0]), .dq_in(dq_in[0]));

  nand_async_cycle_gen #(.DQ_WIDTH(8), .NUM_CE(3), .T_SETUP(1), .T_PULSE(2), .T_HOLD(1), .CE_IDLE(0)) dut1 (
    .clk0(clk0), .rst0(rst0), .req_valid(req_valid[1]), .req_ready(rdy[1]), .req_type(req_type[1]),
    .req_ce(req_ce[1]), .req_data(req_data[1]), .rsp_valid(rv[1]), .rsp_data(rd[1]), .err(err[1]),
    .cle(cle[1]), .ale(ale[1]), .wen(wen[1]), .wrn(wrn[1]), .cen(cen1), .dq_out(dqo[1]),
    .dq_oe_n(oen[1]), .dq_in(dq_in[1]));

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: a bus cycle is described by its accept edge e0; pin
  // values follow from the cycle index c = edges since e0 (+1).
  typedef struct { logic [1:0] t; int ce; logic [7:0] data; int gap; } req_t;
  req_t rq[ND][$];

  int         e0[ND], err_edge[ND], pend_edge[ND], rdy_edge[ND], wait_cnt[ND], mce[ND], pend_ce[ND];
  logic [1:0] mt[ND], pend_t[ND];
  logic [7:0] last_dq[ND], rsp_m[ND], pend_cap[ND], pend_data[ND];
  logic       pend_bad[ND];

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      e0[d] = -1000; err_edge[d] = -1; pend_edge[d] = -1; rdy_edge[d] = 1 << 30;
      wait_cnt[d] = 0; mce[d] = 0; mt[d] = T_CMD; last_dq[d] = 8'h00; rsp_m[d] = 8'h00;
    end
  endtask

  task automatic check_dut(input int d);
    int c, L;
    bit b;
    logic [3:0] ecen, ocen, mask;
    string p;
    if (pend_edge[d] == ecnt) begin
      if (pend_bad[d]) err_edge[d] = ecnt;
      else begin
        e0[d] = ecnt; mt[d] = pend_t[d]; mce[d] = pend_ce[d];
        if (pend_t[d] != T_DOUT) last_dq[d] = pend_data[d];
      end
      pend_edge[d] = -1;
    end
    L = ts[d] + tp[d] + th[d];
    c = ecnt - e0[d] + 1;
    b = (c >= 1) && (c <= L);
    if (b && mt[d] == T_DOUT && c == ts[d] + tp[d] + 1) rsp_m[d] = pend_cap[d];
    mask = 4'((1 << nce[d]) - 1);
    ecen = mask;
    if (b || (c > L && c <= L + tid[d])) ecen[mce[d]] = 1'b0;
    ocen = (d == 0) ? cen0 : {1'b0, cen1};
    p = $sformatf("d%0d@%0d ", d, ecnt);
    chk({p, "req_ready"}, 32'(rdy[d]), 32'(ecnt >= rdy_edge[d] && !b));
    chk({p, "cen"},       32'(ocen),   32'(ecen));
    chk({p, "cen_1hot"},  32'($countones(~ocen & mask) <= 1), 32'(1));
    chk({p, "cle"},       32'(cle[d]), 32'(b && mt[d] == T_CMD));
    chk({p, "ale"},       32'(ale[d]), 32'(b && mt[d] == T_ADDR));
    chk({p, "wen"},       32'(wen[d]), 32'(!(b && mt[d] != T_DOUT && c > ts[d] && c <= ts[d] + tp[d])));
    chk({p, "wrn"},       32'(wrn[d]), 32'(!(b && mt[d] == T_DOUT && c > ts[d] && c <= ts[d] + tp[d])));
    chk({p, "dq_oe_n"},   32'(oen[d]), 32'(!(b && mt[d] != T_DOUT)));
    chk({p, "dq_out"},    32'(dqo[d]), 32'(last_dq[d]));
    chk({p, "rsp_valid"}, 32'(rv[d]),  32'(b && mt[d] == T_DOUT && c == ts[d] + tp[d] + 1));
    chk({p, "rsp_data"},  32'(rd[d]),  32'(rsp_m[d]));
    chk({p, "err"},       32'(err[d]), 32'(err_edge[d] == ecnt));
  endtask

  task automatic drive_dut(input int d);
    int c, L;
    bit b, r;
    req_t h;
    L = ts[d] + tp[d] + th[d];
    c = ecnt - e0[d] + 1;
    b = (c >= 1) && (c <= L);
    r = (ecnt >= rdy_edge[d]) && !b;
    dq_in[d] = 8'($urandom);
    if (b && mt[d] == T_DOUT && c == ts[d] + tp[d]) pend_cap[d] = dq_in[d];
    req_type[d] = 2'($urandom);
    req_ce[d]   = 2'($urandom);
    req_data[d] = 8'($urandom);
    req_valid[d] = 1'b0;
    if (!r) req_valid[d] = 1'($urandom);  // must be ignored while busy
    else if (rq[d].size() > 0) begin
      if (wait_cnt[d] < rq[d][0].gap) wait_cnt[d]++;
      else begin
        h = rq[d].pop_front();
        wait_cnt[d] = 0;
        req_valid[d] = 1'b1; req_type[d] = h.t; req_ce[d] = 2'(h.ce); req_data[d] = h.data;
        pend_edge[d] = ecnt + 1; pend_bad[d] = (h.ce >= nce[d]);
        pend_t[d] = h.t; pend_ce[d] = h.ce; pend_data[d] = h.data;
      end
    end
  endtask

  task automatic step();
    @(negedge clk0);
    for (int d = 0; d < ND; d++) check_dut(d);
    for (int d = 0; d < ND; d++) drive_dut(d);
  endtask

  // Asynchronous reset in mid-cycle: outputs must be at reset values before any edge.
  task automatic reset_pulse();
    #2 rst0 = 1'b1;
    #1 model_reset();
    for (int d = 0; d < ND; d++) check_dut(d);
    #1 rst0 = 1'b0;
    for (int d = 0; d < ND; d++) rdy_edge[d] = ecnt + 1;
  endtask

  initial begin
    bit hit;
    req_t r;
    for (int d = 0; d < ND; d++) begin
      req_valid[d] = 1'b0; req_type[d] = 2'd0; req_ce[d] = 2'd0; req_data[d] = 8'h00; dq_in[d] = 8'h00;
    end
    model_reset();
    repeat (2) @(negedge clk0);
    reset_pulse();

    // dut 0: CMD, read, same-CE hold-off reuse, release, CE switch in window
    rq[0].push_back('{t: T_CMD,  ce: 2, data: 8'h70, gap: 0});
    rq[0].push_back('{t: T_DOUT, ce: 1, data: 8'h00, gap: 0});
    rq[0].push_back('{t: T_ADDR, ce: 2, data: 8'h11, gap: 0});
    rq[0].push_back('{t: T_ADDR, ce: 2, data: 8'h22, gap: 2});
    rq[0].push_back('{t: T_ADDR, ce: 2, data: 8'h33, gap: 8});
    rq[0].push_back('{t: T_DIN,  ce: 0, data: 8'hC4, gap: 1});
    // dut 1: out-of-range CE (twice back to back), then normal traffic
    rq[1].push_back('{t: T_CMD,  ce: 3, data: 8'hFF, gap: 0});
    rq[1].push_back('{t: T_ADDR, ce: 3, data: 8'h01, gap: 0});
    rq[1].push_back('{t: T_CMD,  ce: 1, data: 8'h55, gap: 1});
    rq[1].push_back('{t: T_DOUT, ce: 2, data: 8'h00, gap: 0});
    rq[1].push_back('{t: T_DIN,  ce: 0, data: 8'h9A, gap: 3});
    rq[1].push_back('{t: T_DIN,  ce: 3, data: 8'h9B, gap: 0});
    repeat (80) step();

    // Reset in the middle of a CMD PULSE, then a fresh CMD
    rq[0].push_back('{t: T_CMD, ce: 1, data: 8'h3C, gap: 0});
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      step();
      if (ecnt - e0[0] + 1 == ts[0] + 2) hit = 1'b1;
    end
    chk("rst_mid_pulse_reached", 32'(hit), 32'(1));
    reset_pulse();
    rq[0].push_back('{t: T_CMD, ce: 3, data: 8'h90, gap: 0});
    repeat (20) step();

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      for (int d = 0; d < ND; d++) begin
        if (rq[d].size() == 0) begin
          r.t = 2'($urandom);
          r.ce = int'($urandom_range(0, 3));
          r.data = 8'($urandom);
          r.gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : 0;
          rq[d].push_back(r);
        end
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/nand_async_cycle_gen.md
# nand_async_cycle_gen

Parametrised asynchronous-mode NAND bus-cycle generator that sits beside the DDR DQ/DQS PHY and drives CLE, ALE, WE#, RE# (wrn), CE# and the DQ output enable for command, address, data-in and data-out cycles. It generalises the fixed two-CE command path to NUM_CE chip enables and DQ_WIDTH data bits. It also adds programmable setup/pulse/hold timing, a valid/ready request handshake, read-data capture and CE# idle hold-off. All pin-facing outputs are registered in the clk0 domain.

## Interface
- DQ_WIDTH, 8: DQ bus width.
- NUM_CE, 2: number of chip enables (≥1); CE_W = max(1, clog2(NUM_CE)).
- T_SETUP, 1: cycles in SETUP (≥1).
- T_PULSE, 2: cycles WE#/RE# held low (≥1).
- T_HOLD, 1: cycles in HOLD (≥1).
- CE_IDLE, 4: idle cycles CE# stays low after a bus cycle (0 = release on entering IDLE).

Ports:
- clk0  in  1  sole clock.
- rst0  in  1  reset; asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_type  in  2  0=CMD, 1=ADDR, 2=DIN (write to NAND), 3=DOUT (read from NAND).
- req_ce  in  CE_W  target chip-enable index.
- req_data  in  DQ_WIDTH  command/address/write byte.
- rsp_valid  out  1  one-cycle pulse with read data.
- rsp_data  out  DQ_WIDTH  captured read byte.
- err  out  1  one-cycle pulse: out-of-range req_ce.
- cle, ale  out  1 each  NAND latch enables.
- wen  out  1  WE# (active low).
- wrn  out  1  RE# (active low).
- cen  out  NUM_CE  CE# (active low, one-hot-low).
- dq_out  out  DQ_WIDTH  DQ drive value.
- dq_oe_n  out  1  DQ output enable (active low).
- dq_in  in  DQ_WIDTH  DQ pad input.

## Operation
- States: IDLE, SETUP, PULSE, HOLD. One down-counter, reloaded on each state entry.
- IDLE: req_ready=1. On req_valid&&req_ready:
  - req_ce ≥ NUM_CE: request is consumed. err pulses for 1 cycle, state stays IDLE, no pin changes.
  - Otherwise: latch type/ce/data and go to SETUP.
- SETUP (T_SETUP cycles):
  - cen[ce]=0, all other cen bits =1.
  - CMD: cle=1. ADDR: ale=1. DIN/DOUT: cle=ale=0.
  - CMD/ADDR/DIN: dq_oe_n=0, dq_out=latched data. DOUT: dq_oe_n=1.
- PULSE (T_PULSE cycles): same as SETUP, plus wen=0 (CMD/ADDR/DIN) or wrn=0 (DOUT).
- HOLD (T_HOLD cycles):
  - wen=wrn=1. cle/ale/dq_out/dq_oe_n are held from PULSE.
  - DOUT: dq_in is registered on the clock edge ending the last PULSE cycle. rsp_valid=1 and rsp_data=that value during the first HOLD cycle only.
- HOLD → IDLE: cle=ale=0, dq_oe_n=1; dq_out keeps its last value.
- CE hold-off:
  - In IDLE, cen[ce] stays low for CE_IDLE cycles, then goes all-ones.
  - A new request to the same CE inside the window keeps cen low with no glitch.
  - A request to a different CE releases the old CE and asserts the new one on the same edge (entry to SETUP).
- Reset (async, any state): state=IDLE, cen=all 1, cle=ale=0, wen=wrn=1, dq_oe_n=1, dq_out=0, rsp_valid=0, rsp_data=0, err=0, req_ready=0, idle counter cleared.

## Timing
- req_ready is a register: 0 in reset, 1 on the first clk0 edge after rst0 deasserts. It drops on the accept edge and re-asserts on the edge leaving HOLD.
- Pins change on the accept edge E0.
- Cycle lengths:
  - Bus cycle = T_SETUP+T_PULSE+T_HOLD clocks.
  - Back-to-back period = T_SETUP+T_PULSE+T_HOLD+1 clocks, since one IDLE cycle is mandatory.
  - Out-of-range request: err rises one cycle after accept, and req_ready stays 1.
- Read latency: rsp_valid rises T_SETUP+T_PULSE clocks after E0.
- Request inputs are ignored outside IDLE.

## Test plan
1. T_SETUP=2, T_PULSE=3, T_HOLD=1, NUM_CE=4. CMD 0x70 to CE 2 -> cen=4'b1011 and cle=1 for 6 cycles; wen=0 in cycles 3–5; dq_out=0x70 with dq_oe_n=0 for 6 cycles; req_ready low 6 cycles, high on cycle 7.
2. DOUT to CE 1 with dq_in=0xA5 through PULSE -> wrn=0 for 3 cycles, dq_oe_n=1 throughout, rsp_valid=1 with rsp_data=0xA5 for exactly 1 cycle at cycle 6.
3. CE_IDLE=4: two ADDR cycles to CE 2, the second issued 2 cycles after idle -> cen[2] never rises. After the last cycle, cen returns to 4'b1111 exactly 4 idle cycles later.
4. ADDR to CE 2 then DIN to CE 0 inside the hold-off window -> cen goes 4'b1011→4'b1110 in one edge, never two CEs low.
5. NUM_CE=3, req_ce=3 -> err=1 for one cycle, cen stays 3'b111, wen stays 1, no state change, req_ready stays 1.
6. rst0 pulsed mid-PULSE of a CMD -> outputs take reset values before the next clk0 edge. req_ready=1 one clock after release; a fresh CMD then completes normally.
